// File: rtl/dmem_pkg.sv
// Shared types and constants for the data-memory responder slice.
package dmem_pkg;

  localparam int XLEN      = 64;
  localparam int STRB_W    = 8;
  localparam int DEPTH_DEF = 1024;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUSY = 2'd1,
    RESP = 2'd2
  } state_t;

endpackage

// File: rtl/dmem_if.sv
// Request/response bus between a requester (master) and the memory responder (slave).
interface dmem_if;
  import dmem_pkg::*;

  logic              req_valid;
  logic              req_ready;
  logic              req_write;
  logic [XLEN-1:0]   req_addr;
  logic [XLEN-1:0]   req_wdata;
  logic [STRB_W-1:0] req_wstrb;
  logic              rsp_valid;
  logic              rsp_ready;
  logic [XLEN-1:0]   rsp_rdata;
  logic              rsp_err;

  modport master (
    output req_valid, req_write, req_addr, req_wdata, req_wstrb, rsp_ready,
    input  req_ready, rsp_valid, rsp_rdata, rsp_err
  );

  modport slave (
    input  req_valid, req_write, req_addr, req_wdata, req_wstrb, rsp_ready,
    output req_ready, rsp_valid, rsp_rdata, rsp_err
  );

endinterface

// File: rtl/dmem_array.sv
// DEPTH x 64-bit storage: byte-masked synchronous write, combinational read.
module dmem_array
  import dmem_pkg::*;
#(
  parameter int DEPTH = DEPTH_DEF,
  parameter int AW    = $clog2(DEPTH)
) (
  input  logic              clock,
  input  logic              we,
  input  logic [STRB_W-1:0] wstrb,
  input  logic [AW-1:0]     waddr,
  input  logic [XLEN-1:0]   wdata,
  input  logic [AW-1:0]     raddr,
  output logic [XLEN-1:0]   rdata
);

  logic [XLEN-1:0] mem [DEPTH];

  always_ff @(posedge clock) begin
    for (int b = 0; b < STRB_W; b++) begin
      if (we && wstrb[b]) begin
        mem[waddr][8*b +: 8] <= wdata[8*b +: 8];
      end
    end
  end

  assign rdata = mem[raddr];

endmodule

// File: rtl/dmem_responder.sv
// Single-outstanding memory responder: latches a request, waits LATENCY edges,
// performs the access, then holds the response until the requester takes it.
module dmem_responder
  import dmem_pkg::*;
#(
  parameter int DEPTH   = DEPTH_DEF,
  parameter int LATENCY = 2
) (
  input logic   clock,
  input logic   reset,
  dmem_if.slave bus
);

  localparam int              AW    = $clog2(DEPTH);
  localparam logic [XLEN-1:0] LIMIT = XLEN'(DEPTH) << 3;

  function automatic logic addr_err(input logic [XLEN-1:0] addr);
    return (addr[2:0] != 3'd0) || (addr >= LIMIT);
  endfunction

  state_t            state, state_nxt;
  logic [3:0]        cnt, cnt_nxt;
  logic              accept, access;

  logic              write_p0;
  logic [XLEN-1:0]   addr_p0;
  logic [XLEN-1:0]   wdata_p0;
  logic [STRB_W-1:0] wstrb_p0;
  logic              err_p0;
  logic [AW-1:0]     index_p0;

  logic              mem_we;
  logic [XLEN-1:0]   mem_rdata;
  logic [XLEN-1:0]   rdata_q;
  logic              err_q;

  always_comb begin
    state_nxt = state;
    cnt_nxt   = cnt;
    accept    = 1'b0;
    access    = 1'b0;
    case (state)
      IDLE: begin
        if (bus.req_valid) begin
          accept    = 1'b1;
          cnt_nxt   = 4'(LATENCY - 1);
          state_nxt = BUSY;
        end
      end
      BUSY: begin
        if (cnt != 4'd0) begin
          cnt_nxt = cnt - 4'd1;
        end else begin
          access    = 1'b1;
          state_nxt = RESP;
        end
      end
      RESP: begin
        if (bus.rsp_ready) state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state <= IDLE;
      cnt   <= 4'd0;
    end else begin
      state <= state_nxt;
      cnt   <= cnt_nxt;
    end
  end

  // Request capture stage: later changes on the bus are ignored until IDLE.
  always_ff @(posedge clock) begin
    if (accept) begin
      write_p0 <= bus.req_write;
      addr_p0  <= bus.req_addr;
      wdata_p0 <= bus.req_wdata;
      wstrb_p0 <= bus.req_wstrb;
    end
  end

  assign err_p0   = addr_err(addr_p0);
  assign index_p0 = addr_p0[AW+2:3];
  // Reset on the access edge must win, so the write enable is gated by it too.
  assign mem_we   = access && write_p0 && !err_p0 && !reset;

  dmem_array #(
    .DEPTH (DEPTH),
    .AW    (AW)
  ) u_array (
    .clock (clock),
    .we    (mem_we),
    .wstrb (wstrb_p0),
    .waddr (index_p0),
    .wdata (wdata_p0),
    .raddr (index_p0),
    .rdata (mem_rdata)
  );

  // Response stage: captured once at the access edge, held through RESP.
  always_ff @(posedge clock) begin
    if (reset) begin
      rdata_q <= '0;
      err_q   <= 1'b0;
    end else if (access) begin
      err_q   <= err_p0;
      rdata_q <= (write_p0 || err_p0) ? '0 : mem_rdata;
    end
  end

  assign bus.req_ready = (state == IDLE);
  assign bus.rsp_valid = (state == RESP);
  assign bus.rsp_rdata = rdata_q;
  assign bus.rsp_err   = err_q;

endmodule

// File: tb/tb_dmem_responder.sv
// Directed bench for dmem_responder: LATENCY=2 instance for function/reset cases,
// LATENCY=1 instance for back-to-back streaming.
module tb_dmem_responder;
  import dmem_pkg::*;

  logic clock = 1'b0;
  logic reset = 1'b1;
  int   n_tests = 0;
  int   n_fail  = 0;

  always #5 clock = ~clock;

  dmem_if bus_a ();
  dmem_if bus_b ();

  dmem_responder #(.DEPTH(1024), .LATENCY(2)) u_dut (
    .clock (clock),
    .reset (reset),
    .bus   (bus_a)
  );

  dmem_responder #(.DEPTH(1024), .LATENCY(1)) u_dut1 (
    .clock (clock),
    .reset (reset),
    .bus   (bus_b)
  );

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
    end
  endtask

  // One full transaction on the LATENCY=2 instance; rsp_ready is held high from the
  // start when stall==0 (ignored outside RESP), otherwise withheld for stall cycles.
  task automatic do_req(input string tag, input logic wr, input logic [63:0] addr,
                        input logic [63:0] wdata, input logic [7:0] strb, input int stall,
                        input logic [63:0] exp_rdata, input logic exp_err);
    int lat;
    check({tag, "_ready"}, bus_a.req_ready, 1);
    bus_a.req_valid = 1'b1;
    bus_a.req_write = wr;
    bus_a.req_addr  = addr;
    bus_a.req_wdata = wdata;
    bus_a.req_wstrb = strb;
    bus_a.rsp_ready = (stall == 0);
    @(posedge clock); #1;
    // Keep req_valid high with different contents: must not disturb the latched request.
    bus_a.req_write = ~wr;
    bus_a.req_addr  = 64'h0;
    bus_a.req_wdata = '1;
    bus_a.req_wstrb = '1;
    lat = 0;
    while (!bus_a.rsp_valid && lat < 20) begin
      @(posedge clock); #1;
      lat++;
    end
    check({tag, "_lat"}, 64'(lat), 64'd2);
    check({tag, "_rdata"}, bus_a.rsp_rdata, exp_rdata);
    check({tag, "_err"}, 64'(bus_a.rsp_err), 64'(exp_err));
    check({tag, "_resp_ready"}, bus_a.req_ready, 0);
    for (int i = 0; i < stall; i++) begin
      @(posedge clock); #1;
      check({tag, "_hold_valid"}, bus_a.rsp_valid, 1);
      check({tag, "_hold_rdata"}, bus_a.rsp_rdata, exp_rdata);
      check({tag, "_hold_err"}, 64'(bus_a.rsp_err), 64'(exp_err));
      check({tag, "_hold_ready"}, bus_a.req_ready, 0);
    end
    bus_a.req_valid = 1'b0;
    bus_a.rsp_ready = 1'b1;
    @(posedge clock); #1;
    bus_a.rsp_ready = 1'b0;
    check({tag, "_idle_ready"}, bus_a.req_ready, 1);
    check({tag, "_idle_valid"}, bus_a.rsp_valid, 0);
  endtask

  // Accept a request, then assert reset `edges` edges later (0: mid-BUSY,
  // 1: on the access edge, 2: while in RESP).
  task automatic abort_req(input string tag, input logic wr, input logic [63:0] addr,
                           input logic [63:0] wdata, input int edges);
    bus_a.req_valid = 1'b1;
    bus_a.req_write = wr;
    bus_a.req_addr  = addr;
    bus_a.req_wdata = wdata;
    bus_a.req_wstrb = 8'hFF;
    bus_a.rsp_ready = 1'b0;
    @(posedge clock); #1;
    bus_a.req_valid = 1'b0;
    repeat (edges) begin
      @(posedge clock); #1;
    end
    if (edges == 2) check({tag, "_pre_valid"}, bus_a.rsp_valid, 1);
    reset = 1'b1;
    @(posedge clock); #1;
    reset = 1'b0;
    check({tag, "_ready"}, bus_a.req_ready, 1);
    check({tag, "_valid"}, bus_a.rsp_valid, 0);
    check({tag, "_err"}, 64'(bus_a.rsp_err), 0);
    check({tag, "_rdata"}, bus_a.rsp_rdata, 0);
    for (int i = 0; i < 3; i++) begin
      @(posedge clock); #1;
      check({tag, "_quiet"}, bus_a.rsp_valid, 0);
    end
  endtask

  initial begin
    logic [63:0] wdata_b [4];
    logic [63:0] addr_b  [4];
    logic        wr_b    [4];
    logic [63:0] exp_b   [4];
    int          nreq, nrsp, last;

    bus_a.req_valid = 1'b0; bus_a.req_write = 1'b0; bus_a.req_addr = '0;
    bus_a.req_wdata = '0;   bus_a.req_wstrb = '0;   bus_a.rsp_ready = 1'b0;
    bus_b.req_valid = 1'b0; bus_b.req_write = 1'b0; bus_b.req_addr = '0;
    bus_b.req_wdata = '0;   bus_b.req_wstrb = '0;   bus_b.rsp_ready = 1'b0;

    repeat (3) @(posedge clock);
    #1;
    reset = 1'b0;
    check("rst_ready", bus_a.req_ready, 1);
    check("rst_valid", bus_a.rsp_valid, 0);
    check("rst_err", 64'(bus_a.rsp_err), 0);
    check("rst_rdata", bus_a.rsp_rdata, 0);

    do_req("st8",    1, 64'h8,    64'h1F,                 8'hFF, 0, 64'h0, 0);
    do_req("ld8",    0, 64'h8,    64'h0,                  8'h00, 0, 64'h1F, 0);
    do_req("st10z",  1, 64'h10,   64'h0,                  8'hFF, 0, 64'h0, 0);
    do_req("st10lo", 1, 64'h10,   64'hAABBCCDD_11223344,  8'h0F, 0, 64'h0, 0);
    do_req("ld10a",  0, 64'h10,   64'h0,                  8'h00, 0, 64'h00000000_11223344, 0);
    do_req("st10hi", 1, 64'h10,   64'h55667788_99AABBCC,  8'hF0, 0, 64'h0, 0);
    do_req("ld10b",  0, 64'h10,   64'h0,                  8'h00, 0, 64'h55667788_11223344, 0);
    do_req("st10s0", 1, 64'h10,   64'hFFFFFFFF_FFFFFFFF,  8'h00, 0, 64'h0, 0);
    do_req("ld10c",  0, 64'h10,   64'h0,                  8'h00, 0, 64'h55667788_11223344, 0);
    do_req("st0",    1, 64'h0,    64'h01234567_89ABCDEF,  8'hFF, 0, 64'h0, 0);
    do_req("ldmis",  0, 64'h4,    64'h0,                  8'h00, 0, 64'h0, 1);
    do_req("ldoor",  0, 64'h2000, 64'h0,                  8'h00, 0, 64'h0, 1);
    do_req("stoor",  1, 64'h2000, 64'hFFFFFFFF_FFFFFFFF,  8'hFF, 0, 64'h0, 1);
    do_req("stmis",  1, 64'h1,    64'hFFFFFFFF_FFFFFFFF,  8'hFF, 0, 64'h0, 1);
    do_req("ldhi",   0, 64'h80000000_00000000, 64'h0,     8'h00, 0, 64'h0, 1);
    do_req("ld0",    0, 64'h0,    64'h0,                  8'h00, 0, 64'h01234567_89ABCDEF, 0);
    do_req("sttop",  1, 64'h1FF8, 64'h0000CAFE_0000BEEF,  8'hFF, 0, 64'h0, 0);
    do_req("ldtop",  0, 64'h1FF8, 64'h0,                  8'h00, 0, 64'h0000CAFE_0000BEEF, 0);
    do_req("stall",  0, 64'h8,    64'h0,                  8'h00, 5, 64'h1F, 0);

    do_req("st18",   1, 64'h18,   64'h0,                  8'hFF, 0, 64'h0, 0);
    abort_req("ab_busy", 1, 64'h18, 64'hFF, 0);
    do_req("ld18a",  0, 64'h18,   64'h0,                  8'h00, 0, 64'h0, 0);
    abort_req("ab_acc",  1, 64'h18, 64'hFF, 1);
    do_req("ld18b",  0, 64'h18,   64'h0,                  8'h00, 0, 64'h0, 0);
    abort_req("ab_rsp_st",  1, 64'h20, 64'h77, 2);
    do_req("ld20",   0, 64'h20,   64'h0,                  8'h00, 0, 64'h77, 0);
    abort_req("ab_rsp_ld",  0, 64'h8,  64'h0,  2);
    abort_req("ab_rsp_err", 0, 64'h4,  64'h0,  2);
    do_req("ld8kept", 0, 64'h8,   64'h0,                  8'h00, 0, 64'h1F, 0);

    // LATENCY=1 stream: accept edge, access edge, handshake edge, so one response
    // every 3 cycles with the requester always ready.
    wr_b    = '{1'b1, 1'b1, 1'b0, 1'b0};
    addr_b  = '{64'h40, 64'h48, 64'h40, 64'h48};
    wdata_b = '{64'hDEADBEEF_CAFEF00D, 64'h01234567_89ABCDEF, 64'h0, 64'h0};
    exp_b   = '{64'h0, 64'h0, 64'hDEADBEEF_CAFEF00D, 64'h01234567_89ABCDEF};
    nreq = 0; nrsp = 0; last = 0;
    bus_b.rsp_ready = 1'b1;
    for (int cyc = 0; cyc < 40 && nrsp < 4; cyc++) begin
      if (bus_b.rsp_valid) begin
        check("b_rdata", bus_b.rsp_rdata, exp_b[nrsp]);
        check("b_err", 64'(bus_b.rsp_err), 0);
        if (nrsp == 0) check("b_first", 64'(cyc), 64'd2);
        else           check("b_interval", 64'(cyc - last), 64'd3);
        last = cyc;
        nrsp++;
      end
      if (bus_b.req_ready && nreq < 4) begin
        bus_b.req_valid = 1'b1;
        bus_b.req_write = wr_b[nreq];
        bus_b.req_addr  = addr_b[nreq];
        bus_b.req_wdata = wdata_b[nreq];
        bus_b.req_wstrb = 8'hFF;
        nreq++;
      end else begin
        bus_b.req_valid = 1'b0;
      end
      @(posedge clock); #1;
    end
    check("b_count", 64'(nrsp), 64'd4);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout, expected completion");
    $fatal(1, "watchdog expired");
  end

endmodule
